// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: operation codes, FSM states, control width.
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  typedef enum logic [ALU_CTRL_W-1:0] {
    AluAnd   = 4'b0000,
    AluOr    = 4'b0001,
    AluAdd   = 4'b0010,
    AluSltu  = 4'b0011,
    AluSub   = 4'b0110,
    AluSlt   = 4'b0111,
    AluMultu = 4'b1000,
    AluDivu  = 4'b1001,
    AluMfhi  = 4'b1011,
    AluNor   = 4'b1100,
    AluMflo  = 4'b1101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StDone
  } state_e;

endpackage

// File: rtl/alu_md_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide datapath owning HI/LO.
module alu_md_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] lo_next,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] CntInit = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt_q;
  logic             div_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // acc holds the partial product high half / remainder; sh holds multiplier / quotient bits.
  always_comb begin
    acc_d   = acc_q;
    sh_d    = sh_q;
    sum     = '0;
    shifted = '0;
    diff    = '0;
    if (div_q) begin
      shifted = {acc_q, sh_q[WIDTH-1]};
      diff    = {1'b0, shifted} - {2'b00, opnd_q};
      if (!diff[WIDTH+1]) begin
        acc_d = diff[WIDTH-1:0];
        sh_d  = {sh_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = shifted[WIDTH-1:0];
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum  = sh_q[0] ? ({1'b0, acc_q} + {1'b0, opnd_q}) : {1'b0, acc_q};
      acc_d = sum[WIDTH:1];
      sh_d  = {sum[0], sh_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      div_q  <= 1'b0;
      opnd_q <= '0;
      acc_q  <= '0;
      sh_q   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (start) begin
      cnt_q  <= CntInit;
      div_q  <= is_div;
      opnd_q <= is_div ? op_b : op_a;
      acc_q  <= '0;
      sh_q   <= is_div ? op_a : op_b;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
      acc_q <= acc_d;
      sh_q  <= sh_d;
      if (done) begin
        hi_q <= acc_d;
        lo_q <= sh_d;
      end
    end
  end

  assign done    = (cnt_q == CNT_W'(1));
  assign dbz     = div_q && (opnd_q == '0);
  assign lo_next = sh_d;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: rtl/alu_md_unit.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative MULTU/DIVU into HI/LO,
// with valid/ready handshake on both sides and registered result and flags.
module alu_md_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]      src1,
  input  logic [WIDTH-1:0]      src2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      result,
  output logic                  zero,
  output logic                  overflow,
  output logic                  div_by_zero,
  output logic                  illegal,
  output logic                  busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;
  logic             ill_q, ill_d;

  alu_ctrl_e        op;
  logic [WIDTH-1:0] sum, diff, op_res;
  logic             start, is_div;
  logic             iter_done, iter_dbz;
  logic [WIDTH-1:0] lo_next, hi, lo;

  assign op   = alu_ctrl_e'(alu_ctrl);
  assign sum  = src1 + src2;
  assign diff = src1 - src2;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    ill_d    = ill_q;
    op_res   = '0;
    start    = 1'b0;
    is_div   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          ovf_d   = 1'b0;
          dbz_d   = 1'b0;
          ill_d   = 1'b0;
          state_d = StDone;
          case (op)
            AluAnd:  op_res = src1 & src2;
            AluOr:   op_res = src1 | src2;
            AluNor:  op_res = ~(src1 | src2);
            AluAdd: begin
              op_res = sum;
              ovf_d  = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]);
            end
            AluSub: begin
              op_res = diff;
              ovf_d  = (src1[WIDTH-1] != src2[WIDTH-1]) && (diff[WIDTH-1] != src1[WIDTH-1]);
            end
            AluSltu: op_res = {{(WIDTH-1){1'b0}}, (src1 < src2)};
            AluSlt:  op_res = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
            AluMfhi: op_res = hi;
            AluMflo: op_res = lo;
            AluMultu, AluDivu: begin
              // Flags and result keep their previous values until the iteration finishes.
              ovf_d   = ovf_q;
              dbz_d   = dbz_q;
              ill_d   = ill_q;
              start   = 1'b1;
              is_div  = (op == AluDivu);
              state_d = StIter;
            end
            default: begin
              op_res = '0;
              ill_d  = 1'b1;
            end
          endcase
          if (state_d == StDone) begin
            result_d = op_res;
            zero_d   = (op_res == '0);
          end
        end
      end
      StIter: begin
        if (iter_done) begin
          result_d = lo_next;
          zero_d   = (lo_next == '0);
          ovf_d    = 1'b0;
          ill_d    = 1'b0;
          dbz_d    = iter_dbz;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
      ill_q    <= ill_d;
    end
  end

  alu_md_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .is_div  (is_div),
    .op_a    (src1),
    .op_b    (src2),
    .done    (iter_done),
    .dbz     (iter_dbz),
    .lo_next (lo_next),
    .hi      (hi),
    .lo      (lo)
  );

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign busy        = (state_q == StIter);
  assign result      = result_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;
  assign illegal     = ill_q;

endmodule

// File: tb/tb_alu_md_unit.sv
// Self-checking bench for alu_md_unit (WIDTH = 32): directed vector table, hand-written
// reset/back-pressure sequences, and random ops against a behavioural model.
module tb_alu_md_unit;

  localparam int W = 32;
  localparam longint SMax = 64'sd2147483647;
  localparam longint SMin = -64'sd2147483648;

  logic         clk, reset;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] src1, src2, result;
  logic         zero, overflow, div_by_zero, illegal, busy;

  int n_pass = 0;
  int n_total = 0;

  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  alu_md_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_ctrl    (alu_ctrl),
    .src1        (src1),
    .src2        (src2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .overflow    (overflow),
    .div_by_zero (div_by_zero),
    .illegal     (illegal),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Behavioural model: results straight from the operation definitions; tracks HI/LO.
  task automatic model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [3:0] flg);
    longint s;
    logic [63:0] p;
    logic ov, dz, il;
    ov = 0; dz = 0; il = 0; r = '0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0010: begin
        r = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        ov = (s > SMax) || (s < SMin);
      end
      4'b0110: begin
        r = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        ov = (s > SMax) || (s < SMin);
      end
      4'b0011: r = (a < b) ? 1 : 0;
      4'b0111: r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1000: begin
        p = {32'b0, a} * {32'b0, b};
        hi_m = p[63:32];
        lo_m = p[31:0];
        r = lo_m;
      end
      4'b1001: begin
        if (b == 0) begin
          lo_m = '1;
          hi_m = a;
          dz = 1;
        end else begin
          lo_m = a / b;
          hi_m = a % b;
        end
        r = lo_m;
      end
      4'b1011: r = hi_m;
      4'b1101: r = lo_m;
      default: il = 1;
    endcase
    flg = {(r == 0), ov, dz, il};
  endtask

  // Issue one op with out_ready high; report outputs, latency (edges) and busy cycles.
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output logic [3:0] flg,
                        output int lat, output int bcnt);
    int wait_cnt;
    wait_cnt = 0;
    @(negedge clk);
    while (!in_ready && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1; alu_ctrl = c; src1 = a; src2 = b;
    @(posedge clk);
    #1;
    in_valid = 0; src1 = $urandom; src2 = $urandom;
    lat = 1; bcnt = 0;
    forever begin
      @(negedge clk);
      if (out_valid || lat > 100) break;
      if (busy) bcnt++;
      @(posedge clk);
      lat++;
    end
    r = result;
    flg = {zero, overflow, div_by_zero, illegal};
  endtask

  typedef struct {
    logic [3:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   flg;  // {zero, overflow, div_by_zero, illegal}
    int           lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [W-1:0] r, mr;
    logic [3:0]   flg, mflg;
    int           lat, bcnt, exp_lat;
    logic [3:0]   c;
    logic [W-1:0] a, b;

    reset = 1; in_valid = 0; out_ready = 1; alu_ctrl = 0; src1 = 0; src2 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {result, zero, overflow, div_by_zero, illegal, out_valid, busy, in_ready},
          {32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    reset = 0;

    // Complete one MULTU so HI is nonzero, then abort a second MULTU with reset.
    model(4'b1000, 32'h12345678, 32'h9abcdef0, mr, mflg);
    run_op(4'b1000, 32'h12345678, 32'h9abcdef0, r, flg, lat, bcnt);
    check("multu_pre_reset", {r, flg}, {mr, mflg});
    @(negedge clk);
    in_valid = 1; alu_ctrl = 4'b1000; src1 = 32'hdeadbeef; src2 = 32'h87654321;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (10) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    check("reset_mid_iter", {result, zero, out_valid, busy, in_ready},
          {32'h0, 1'b1, 1'b0, 1'b0, 1'b1});
    @(posedge clk);
    #1 reset = 0;
    hi_m = '0; lo_m = '0;
    @(negedge clk);
    check("ready_after_reset", {in_ready, out_valid, busy}, 3'b100);
    run_op(4'b1011, 0, 0, r, flg, lat, bcnt);
    check("mfhi_after_reset", {r, flg}, {32'h0, 4'b1000});

    vecs.push_back('{4'b0010, 32'h7fffffff, 32'h1,        32'h80000000, 4'b0100, 1});
    vecs.push_back('{4'b0110, 32'h5,        32'h5,        32'h0,        4'b1000, 1});
    vecs.push_back('{4'b0111, 32'hffffffff, 32'h1,        32'h1,        4'b0000, 1});
    vecs.push_back('{4'b0011, 32'hffffffff, 32'h1,        32'h0,        4'b1000, 1});
    vecs.push_back('{4'b1100, 32'h0,        32'h0,        32'hffffffff, 4'b0000, 1});
    vecs.push_back('{4'b1000, 32'hffffffff, 32'hffffffff, 32'h1,        4'b0000, 33});
    vecs.push_back('{4'b1011, 32'h0,        32'h0,        32'hfffffffe, 4'b0000, 1});
    vecs.push_back('{4'b1101, 32'h0,        32'h0,        32'h1,        4'b0000, 1});
    vecs.push_back('{4'b1001, 32'd100,      32'd7,        32'd14,       4'b0000, 33});
    vecs.push_back('{4'b1011, 32'h0,        32'h0,        32'd2,        4'b0000, 1});
    vecs.push_back('{4'b1001, 32'd9,        32'd0,        32'hffffffff, 4'b0010, 33});
    vecs.push_back('{4'b1011, 32'h0,        32'h0,        32'd9,        4'b0000, 1});
    vecs.push_back('{4'b1111, 32'h1234,     32'h5678,     32'h0,        4'b1001, 1});
    vecs.push_back('{4'b1101, 32'h0,        32'h0,        32'hffffffff, 4'b0000, 1});
    vecs.push_back('{4'b0000, 32'hf0f0f0f0, 32'hff00ff00, 32'hf000f000, 4'b0000, 1});
    vecs.push_back('{4'b0001, 32'hf0f0f0f0, 32'h0f00000f, 32'hfff0f0ff, 4'b0000, 1});
    vecs.push_back('{4'b0110, 32'h80000000, 32'h1,        32'h7fffffff, 4'b0100, 1});
    vecs.push_back('{4'b0110, 32'h0,        32'h1,        32'hffffffff, 4'b0000, 1});

    foreach (vecs[i]) begin
      model(vecs[i].ctrl, vecs[i].a, vecs[i].b, mr, mflg);
      run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, r, flg, lat, bcnt);
      check($sformatf("vec%0d", i), {r, flg, 8'(lat), 8'(bcnt)},
            {vecs[i].res, vecs[i].flg, 8'(vecs[i].lat), 8'((vecs[i].lat == 33) ? 32 : 0)});
    end

    // Back-pressure: result held in DONE, new request ignored until the handshake.
    @(negedge clk);
    out_ready = 0; in_valid = 1; alu_ctrl = 4'b0010; src1 = 3; src2 = 4;
    @(posedge clk);
    #1 alu_ctrl = 4'b0110; src1 = 10; src2 = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {result, out_valid, in_ready, busy}, {32'd7, 1'b1, 1'b0, 1'b0});
    end
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release", {out_valid, in_ready}, 2'b01);
    @(posedge clk);
    #1 in_valid = 0; src1 = $urandom; src2 = $urandom;
    @(negedge clk);
    check("bp_second", {result, out_valid, overflow, zero}, {32'd9, 1'b1, 1'b0, 1'b0});

    for (int i = 0; i < 200; i++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h7fffffff + 32'($urandom_range(0, 2));
      model(c, a, b, mr, mflg);
      exp_lat = (c == 4'b1000 || c == 4'b1001) ? 33 : 1;
      run_op(c, a, b, r, flg, lat, bcnt);
      check($sformatf("rand%0d_op%h", i, c), {r, flg, 8'(lat), 8'(bcnt)},
            {mr, mflg, 8'(exp_lat), 8'((exp_lat == 33) ? 32 : 0)});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_md_unit.md
# alu_md_unit

Parametrised, multi-cycle successor to the single-cycle ALU core. It executes single-cycle logic and arithmetic ops, plus iterative unsigned multiply and divide into HI/LO registers, behind a valid/ready handshake. It sits in the multi-cycle datapath between operand fetch and writeback, and stalls the pipeline control via `in_ready` while a multiply or divide is in flight.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; must be ≥ 4 and even.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: operation request.
- `in_ready` out 1: unit can accept a request.
- `alu_ctrl` in 4: operation code (see Operation).
- `src1` in WIDTH: operand A.
- `src2` in WIDTH: operand B.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes result.
- `result` out WIDTH: registered result.
- `zero` out 1: `result == 0`.
- `overflow` out 1: signed overflow (ADD/SUB only).
- `div_by_zero` out 1: last DIVU had `src2 == 0`.
- `illegal` out 1: undefined `alu_ctrl` accepted.
- `busy` out 1: mult/div iteration in progress.

## Operation
Codes:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0011 SLTU
- 0110 SUB
- 0111 SLT (signed, result 1 or 0)
- 1100 NOR
- 1000 MULTU: {HI,LO} = A×B
- 1001 DIVU: LO = A/B, HI = A%B
- 1011 MFHI: result = HI
- 1101 MFLO: result = LO
- All other codes: illegal.

Rules:
- Arithmetic wraps modulo 2^WIDTH.
- `overflow` = signed overflow of ADD/SUB; it is 0 for every other op.
- MULTU/DIVU write HI/LO only. Their `result` is LO and `zero` reflects LO.
- DIVU with B = 0: LO = all ones, HI = A, `div_by_zero` = 1, still WIDTH iterations.
- Illegal code: `result` = 0, `zero` = 1, `illegal` = 1, HI/LO unchanged.
- Flags (`zero`, `overflow`, `div_by_zero`, `illegal`) are registered with `result` and hold until the next result.

FSM states: IDLE, ITER, DONE.
- IDLE: `in_ready` = 1. On `in_valid`, capture operands and ctrl. MULTU/DIVU go to ITER with counter = WIDTH. All other codes compute and go to DONE.
- ITER: one shift-add (MULTU) or restoring shift-subtract (DIVU) step per cycle; counter decrements. When counter reaches 1, the final step writes HI/LO and the FSM goes to DONE. `busy` = 1.
- DONE: `out_valid` = 1 and outputs are stable. On `out_ready`, go to IDLE. No new request is accepted in DONE.
- MFHI/MFLO read HI/LO as they are at acceptance.

## Timing
- Reset values: FSM IDLE; `result`, HI, LO = 0; `zero` = 1; `overflow`, `div_by_zero`, `illegal`, `out_valid`, `busy` = 0; `in_ready` = 1.
- Reset asserted mid-ITER or in DONE aborts the operation: no result, HI/LO cleared.
- Single-cycle ops: accepted at edge N, `out_valid` high after edge N+1.
- MULTU/DIVU: accepted at edge N, `out_valid` high after edge N+WIDTH+1. `busy` is high for exactly WIDTH cycles.
- Throughput: the earliest next accept is the cycle after the handshake (`out_valid` && `out_ready`). Minimum 2 cycles per single-cycle op.
- `out_ready` held high in DONE completes in the same cycle; back-pressure holds DONE indefinitely.
- `in_valid` is ignored outside IDLE. Operands are sampled only at accept, so later changes to `src1`/`src2` have no effect.

## Structure
- Shared package `alu_pkg`:
  - `alu_ctrl_e` enum with the codes above.
  - FSM state enum.
  - Helper constant `ALU_CTRL_W = 4`.
- Sub-module `alu_md_iter`: the iterative multiply/divide datapath (counter, partial product/remainder, HI/LO registers) with start/done. The top level holds the FSM, the single-cycle ops, the output registers and the handshake.

## Test plan
WIDTH = 32 throughout.
- Reset mid-MULTU (cycle 10), then MFHI → `result` = 0, `in_ready` = 1 immediately after reset release.
- ADD 0x7FFFFFFF + 1 → `result` 0x80000000, `overflow` 1, `zero` 0, `out_valid` 1 cycle after accept. SUB 5 − 5 → `result` 0, `zero` 1.
- SLT 0xFFFFFFFF vs 1 → 1; SLTU same operands → 0; NOR 0 with 0 → 0xFFFFFFFF.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, then MFHI, MFLO → HI 0xFFFFFFFE, LO 0x00000001; first `out_valid` exactly 33 cycles after accept; `busy` high 32 cycles.
- DIVU 100 / 7 → LO 14, HI 2. DIVU 9 / 0 → LO 0xFFFFFFFF, HI 9, `div_by_zero` 1.
- Back-pressure: hold `out_ready` = 0 for 5 cycles after an ADD, with `in_valid` high and new operands applied → output stable, `in_ready` 0, second op accepted only after the handshake. Illegal code 1111 → `illegal` 1, `result` 0.
